// File: rtl/tdc_ro_pkg.sv
// Shared state encoding, m_data field offsets and helpers for the TDC readout mux.
package tdc_ro_pkg;

    localparam int NUM_CH = 8;
    localparam int CH_W   = 3;

    // Field offsets above the payload: m_data[DW+HDR_BIT] is is_hdr, chan sits at DW+CHAN_LSB.
    localparam int HDR_BIT  = 3;
    localparam int CHAN_LSB = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_XFER = 2'd2,
        S_REL  = 2'd3
    } ro_state_t;

    function automatic logic [NUM_CH-1:0] onehot8(input logic [CH_W-1:0] idx);
        return NUM_CH'(1) << idx;
    endfunction

endpackage

// File: rtl/tdc_ro_outreg.sv
// Single-stage valid/ready output register; holds data and last while stalled.
module tdc_ro_outreg #(
    parameter int W = 28
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_last,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic         o_last
);

    logic [W-1:0] r_data;
    logic         r_valid;
    logic         r_last;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_last  = r_last;

endmodule

// File: rtl/tdc_readout_mux.sv
// Drains one burst from the granted TDC channel, tags beats with the channel ID and releases the grant.
// Optional burst header beat with an 8-bit sequence number when TDC_RO_HEADER_EN is defined.
module tdc_readout_mux
    import tdc_ro_pkg::*;
#(
    parameter int DW        = 24,
    parameter int MAX_BURST = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [CH_W-1:0]     grant,
    input  logic [NUM_CH-1:0]   ch_valid,
    input  logic [8*DW-1:0]     ch_data,
    input  logic [NUM_CH-1:0]   ch_last,
    output logic [NUM_CH-1:0]   ch_rd,
    output logic [NUM_CH-1:0]   done,
    output logic [DW+3:0]       m_data,
    output logic                m_valid,
    output logic                m_last,
    input  logic                m_ready
);

    localparam int                CNT_W    = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(MAX_BURST - 1);

    ro_state_t          r_state;
    ro_state_t          w_state_nxt;
    logic [CH_W-1:0]    r_cur_ch;
    logic [CNT_W-1:0]   r_beat_cnt;

    logic               w_can_load;
    logic               w_pop;
    logic               w_latch;
    logic               w_load;
    logic               w_load_last;
    logic [DW+3:0]      w_load_data;
    logic [NUM_CH-1:0]  w_done;
    logic [NUM_CH-1:0]  w_ch_rd;
    logic [DW-1:0]      w_cur_payload;
    logic               w_cur_last;

`ifdef TDC_RO_HEADER_EN
    logic [7:0]         r_seq;
    logic               w_hdr_fire;
`endif

    assign w_can_load    = ~m_valid | m_ready;
    assign w_cur_payload = ch_data[int'(r_cur_ch)*DW +: DW];
    // Forced end of burst once MAX_BURST beats have gone out without ch_last.
    assign w_cur_last    = ch_last[r_cur_ch] | (r_beat_cnt == LAST_CNT);

    always_comb begin
        w_state_nxt = r_state;
        w_done      = '0;
        w_ch_rd     = '0;
        w_pop       = 1'b0;
        w_latch     = 1'b0;
        w_load      = 1'b0;
        w_load_last = 1'b0;
        w_load_data = '0;
`ifdef TDC_RO_HEADER_EN
        w_hdr_fire  = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                // Empty granted channel releases in the same cycle.
                w_done = onehot8(grant) & ~ch_valid;
                if (ch_valid[grant]) begin
                    w_latch = 1'b1;
`ifdef TDC_RO_HEADER_EN
                    w_state_nxt = S_HDR;
`else
                    w_state_nxt = S_XFER;
`endif
                end
            end
`ifdef TDC_RO_HEADER_EN
            S_HDR: begin
                if (w_can_load) begin
                    w_hdr_fire                        = 1'b1;
                    w_load                            = 1'b1;
                    w_load_data[DW+HDR_BIT]           = 1'b1;
                    w_load_data[DW+CHAN_LSB +: CH_W]  = r_cur_ch;
                    w_load_data[DW-1:0]               = DW'(r_seq);
                    w_state_nxt                       = S_XFER;
                end
            end
`endif
            S_XFER: begin
                w_pop   = ch_valid[r_cur_ch] & w_can_load;
                w_ch_rd = onehot8(r_cur_ch) & {NUM_CH{w_pop}};
                if (w_pop) begin
                    w_load                           = 1'b1;
                    w_load_last                      = w_cur_last;
                    w_load_data[DW+CHAN_LSB +: CH_W] = r_cur_ch;
                    w_load_data[DW-1:0]              = w_cur_payload;
                    if (w_cur_last)
                        w_state_nxt = S_REL;
                end
            end
            S_REL: begin
                w_done      = onehot8(r_cur_ch);
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_cur_ch   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_cur_ch   <= grant;
                r_beat_cnt <= '0;
            end else if (w_pop) begin
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
        end
    end

`ifdef TDC_RO_HEADER_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_seq <= '0;
        else if (w_hdr_fire)
            r_seq <= r_seq + 8'd1;
    end
`endif

    tdc_ro_outreg #(
        .W (DW + 4)
    ) u_outreg (
        .clk     (clk),
        .resetn  (resetn),
        .i_load  (w_load),
        .i_data  (w_load_data),
        .i_last  (w_load_last),
        .i_ready (m_ready),
        .o_data  (m_data),
        .o_valid (m_valid),
        .o_last  (m_last)
    );

    assign ch_rd = w_ch_rd;
    assign done  = w_done;

endmodule
